vpu_rsp_encoder: RTL

- Device-to-host response transmitter for the VPU request channel; the return path for instructions that the decoder accepted.
- Accepts completion events from the VPU controller (stream id, write-back address, error flag) and buffers them in a small in-order FIFO.
- Stamps each response with a sequence number and presents it to the host on a valid/ready response channel.
- Sits between the controller completion output and the host-side response interface.

---
 rtl/vpu_rsp_encoder.sv | 125 ++++++++++++
 1 files changed

// File: rtl/vpu_rsp_encoder.sv
// VPU response encoder: buffers controller completion events in an in-order FIFO and
// returns them to the host with a sequence stamp. Optional stall watchdog: VPU_RSP_TIMEOUT_EN.
module vpu_rsp_encoder #(
  parameter int STREAM_ID_WIDTH = 8,
  parameter int ADDR_WIDTH      = 8,
  parameter int FIFO_DEPTH      = 4,
  parameter int SEQ_WIDTH       = 8,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          done_valid_i,
  output logic                          done_ready_o,
  input  logic [STREAM_ID_WIDTH-1:0]    done_stream_id_i,
  input  logic [ADDR_WIDTH-1:0]         done_waddr_i,
  input  logic                          done_err_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [STREAM_ID_WIDTH-1:0]    rsp_stream_id_o,
  output logic [ADDR_WIDTH-1:0]         rsp_waddr_o,
  output logic [1:0]                    rsp_status_o,
  output logic [SEQ_WIDTH-1:0]          rsp_seq_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic [15:0]                   err_cnt_o,
  output logic                          stall_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [STREAM_ID_WIDTH-1:0] sid;
    logic [ADDR_WIDTH-1:0]      waddr;
    logic                       err;
    logic [SEQ_WIDTH-1:0]       seq;
  } entry_t;

  generate
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("vpu_rsp_encoder: FIFO_DEPTH must be a power of two >= 2, TIMEOUT_CYCLES >= 1");
    end
  endgenerate

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [SEQ_WIDTH-1:0] seq;
  logic [15:0] err_cnt;
  entry_t mem [FIFO_DEPTH];
  entry_t head;
  logic full, empty, enq, deq, stall;

  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign empty = (count == '0);
  // Ready looks only at registered occupancy, so a pop never frees a slot in the same cycle.
  assign enq   = done_valid_i & ~full;
  assign deq   = ~empty & rsp_ready_i;

  // Enqueue side: storage holds data only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= '{sid: done_stream_id_i, waddr: done_waddr_i, err: done_err_i, seq: seq};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      seq     <= '0;
      err_cnt <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + 1'b1;
        seq    <= seq + 1'b1;
      end
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (deq && head.err) err_cnt <= sat_inc16(err_cnt);
    end
  end

`ifdef VPU_RSP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;

  // Stall watchdog: stall rises on the cycle the wait count reaches the threshold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      stall    <= 1'b0;
    end else begin
      if (deq || empty)
        wait_cnt <= '0;
      else if (wait_cnt != TW'(TIMEOUT_CYCLES))
        wait_cnt <= wait_cnt + 1'b1;
      if (deq)
        stall <= 1'b0;
      else if (!empty && wait_cnt == TW'(TIMEOUT_CYCLES - 1))
        stall <= 1'b1;
    end
  end
`else
  assign stall = 1'b0;
`endif

  // Response side: head entry is shown only while valid, otherwise all-zero.
  assign head            = mem[rd_ptr];
  assign done_ready_o    = ~full;
  assign rsp_valid_o     = ~empty;
  assign rsp_stream_id_o = empty ? '0 : head.sid;
  assign rsp_waddr_o     = empty ? '0 : head.waddr;
  assign rsp_seq_o       = empty ? '0 : head.seq;
  assign rsp_status_o    = empty ? 2'b00 : (stall ? 2'b10 : {1'b0, head.err});
  assign fifo_count_o    = count;
  assign err_cnt_o       = err_cnt;
  assign stall_o         = stall;

endmodule
